// File: rtl/aes_prng_clearing_arb_if.sv
// Bundle of the consumer-side and PRNG-side handshakes of the clearing-data
// arbiter. The arbiter holds the slave modport. A driver or testbench holds the master modport.
interface aes_prng_clearing_arb_if #(
  parameter int NumReq = 3
);
  // Data handshake: a consumer holds req_i[n] high until it sees ack_o[n].
  // A transfer happens in the cycle where prng_data_req_o and
  // prng_data_ack_i are both high. Reseed handshake: reseed_req_o stays
  // high until the cycle where reseed_ack_i is seen high.
  logic [NumReq-1:0] req_i;
  logic [NumReq-1:0] ack_o;
  logic              prng_data_req_o;
  logic              prng_data_ack_i;
  logic              reseed_trig_i;
  logic              reseed_req_o;
  logic              reseed_ack_i;
  logic              reseed_busy_o;
  logic              reseed_done_o;

  modport slave (
    input  req_i,
    input  prng_data_ack_i,
    input  reseed_trig_i,
    input  reseed_ack_i,
    output ack_o,
    output prng_data_req_o,
    output reseed_req_o,
    output reseed_busy_o,
    output reseed_done_o
  );

  modport master (
    output req_i,
    output prng_data_ack_i,
    output reseed_trig_i,
    output reseed_ack_i,
    input  ack_o,
    input  prng_data_req_o,
    input  reseed_req_o,
    input  reseed_busy_o,
    input  reseed_done_o
  );
endinterface

// File: rtl/aes_prng_clearing_arb.sv
// Round-robin arbiter that shares one clearing PRNG among NumReq consumers.
// It also sequences PRNG reseeds. A reseed starts on a software trigger or
// after ReseedPeriod data grants.
module aes_prng_clearing_arb #(
  parameter int NumReq       = 3,
  parameter int ReseedPeriod = 256,
  parameter int CntW         = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  aes_prng_clearing_arb_if.slave    bus,
  output logic                      o_dbg_state,
  output logic [$clog2(NumReq)-1:0] o_dbg_ptr,
  output logic [CntW-1:0]           o_dbg_cnt,
  output logic                      o_dbg_pend
);

  localparam int              PtrW   = $clog2(NumReq);
  localparam logic [CntW:0]   PERIOD = (CntW+1)'(ReseedPeriod);
  localparam logic [CntW-1:0] CNT_MAX = {CntW{1'b1}};

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RESEED = 1'b1
  } state_t;

  state_t            r_state;
  logic              r_pend;
  logic [PtrW-1:0]   r_ptr;
  logic [CntW-1:0]   r_cnt;
  logic              r_done;

  logic              w_any;
  logic              w_found;
  logic [PtrW-1:0]   w_win;
  logic              w_serve;
  logic              w_grant;
  logic              w_auto;
  logic [CntW-1:0]   w_cnt_inc;
  logic [NumReq-1:0] w_ack;
  int                w_idx;

  // Pick the first requester after the last winner, wrapping around.
  always_comb begin
    w_any   = |bus.req_i;
    w_found = 1'b0;
    w_win   = r_ptr;
    w_idx   = 0;
    for (int i = 1; i <= NumReq; i++) begin
      w_idx = (int'(r_ptr) + i) % NumReq;
      if (!w_found && bus.req_i[w_idx]) begin
        w_found = 1'b1;
        w_win   = PtrW'(w_idx);
      end
    end
  end

  // Data path is only open in IDLE with no reseed pending. Reset closes it immediately.
  assign w_serve   = rst_ni && (r_state == ST_IDLE) && !r_pend && w_any;
  assign w_grant   = w_serve && bus.prng_data_ack_i;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
  assign w_auto    = (ReseedPeriod != 0) && w_grant &&
                     (({1'b0, r_cnt} + 1'b1) == PERIOD);

  // Route the PRNG acknowledge to the winning consumer only.
  always_comb begin
    w_ack = '0;
    if (w_serve) begin
      w_ack[w_win] = bus.prng_data_ack_i;
    end
  end

  // Reseed FSM together with the round-robin pointer and the grant counter.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= ST_IDLE;
      r_pend  <= 1'b0;
      r_ptr   <= PtrW'(NumReq - 1);
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_pend) begin
            r_state <= ST_RESEED;
          end
          if (w_grant) begin
            r_ptr <= w_win;
            r_cnt <= w_cnt_inc;
          end
          // A trigger and an auto-reseed in the same cycle merge into one pending reseed.
          if (bus.reseed_trig_i || w_auto) begin
            r_pend <= 1'b1;
          end
        end
        ST_RESEED: begin
          // Triggers seen here are absorbed because r_pend is already set.
          if (bus.reseed_ack_i) begin
            r_state <= ST_IDLE;
            r_pend  <= 1'b0;
            r_cnt   <= '0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ack_o           = w_ack;
  assign bus.prng_data_req_o = w_serve;
  assign bus.reseed_req_o    = rst_ni && (r_state == ST_RESEED);
  assign bus.reseed_busy_o   = rst_ni && (r_pend || (r_state == ST_RESEED));
  assign bus.reseed_done_o   = r_done;

  assign o_dbg_state = r_state;
  assign o_dbg_ptr   = r_ptr;
  assign o_dbg_cnt   = r_cnt;
  assign o_dbg_pend  = r_pend;

endmodule
